// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards EX results to write-back and runs
// LOAD/SAVE as byte-serial little-endian transfers over an 8-bit handshake.
module mem_stage #(
  parameter logic [6:0] LOAD_OP = 7'b0000011,
  parameter logic [6:0] SAVE_OP = 7'b0100011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [6:0]  in_ins_type,
  input  logic [2:0]  in_ins_details,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_val,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_rd_val,
  input  logic        in_forward,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        wb_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_val,
  output logic        stall_out
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_rd_val_q, wb_rd_val_d;
  logic [1:0]  last_k;
  logic [31:0] ext_val;
  logic        is_mem;

  // Bus outputs derive from state so an async reset drops mem_req at once.
  assign mem_req   = (state_q == S_XFER);
  assign mem_wr    = mem_req & ~load_q;
  assign mem_a     = mem_req ? addr_q + {30'd0, k_q} : 32'd0;
  assign mem_wdata = mem_req ? data_q[{k_q, 3'b000} +: 8] : 8'd0;
  assign stall_out = (state_q != S_IDLE);

  assign wb_we      = wb_we_q;
  assign wb_rd_addr = wb_rd_addr_q;
  assign wb_rd_val  = wb_rd_val_q;

  assign is_mem = (in_ins_type == LOAD_OP) || (in_ins_type == SAVE_OP);
  assign last_k = f3_q[1] ? 2'd3 : (f3_q[0] ? 2'd1 : 2'd0);

  always_comb begin
    case (f3_q)
      3'b000:  ext_val = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b001:  ext_val = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b100:  ext_val = {24'd0, buf_q[7:0]};
      3'b101:  ext_val = {16'd0, buf_q[15:0]};
      default: ext_val = buf_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    load_d       = load_q;
    k_d          = k_q;
    buf_d        = buf_q;
    wb_we_d      = 1'b0;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_val_d  = wb_rd_val_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          addr_d  = in_mem_addr;
          data_d  = in_mem_val;
          f3_d    = in_ins_details;
          rd_d    = in_rd_addr;
          load_d  = (in_ins_type == LOAD_OP);
          k_d     = 2'd0;
          buf_d   = 32'd0;
          state_d = S_XFER;
        end else begin
          wb_we_d      = in_forward && (in_rd_addr != 5'd0);
          wb_rd_addr_d = in_rd_addr;
          wb_rd_val_d  = in_rd_val;
        end
      end
      S_XFER: begin
        if (mem_ack) begin
          if (load_q) buf_d[{k_q, 3'b000} +: 8] = mem_rdata;
          k_d = k_q + 2'd1;
          if (k_q == last_k) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (load_q) begin
          wb_we_d      = (rd_q != 5'd0);
          wb_rd_addr_d = rd_q;
          wb_rd_val_d  = ext_val;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rdy_in low freezes everything, including any ack seen that cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      f3_q         <= 3'd0;
      rd_q         <= 5'd0;
      load_q       <= 1'b0;
      k_q          <= 2'd0;
      buf_q        <= 32'd0;
      wb_we_q      <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_val_q  <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      load_q       <= load_d;
      k_q          <= k_d;
      buf_q        <= buf_d;
      wb_we_q      <= wb_we_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_val_q  <= wb_rd_val_d;
    end
  end
endmodule
